// File: rtl/dct_v2.sv
// Unnormalized 8-point 1-D DCT-II: loads eight unsigned samples, then
// accumulates one product per cycle and streams X[0..7] out with strobes.
module dct_v2 (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [7:0]         data_in,
   output logic signed [31:0] data_out,
   output logic               exportProduct,
   output logic               finish
);

   typedef enum logic [1:0] {IDLE, LOAD, MAC} state_t;

   localparam int unsigned AW = 26;

   state_t               state_q;
   logic [7:0]           x_q [8];
   logic [2:0]           ld_q;
   logic [2:0]           k_q;
   logic [2:0]           n_q;
   logic signed [AW-1:0] acc_q;
   logic signed [AW-1:0] acc_d;
   logic signed [31:0]   data_q;
   logic                 exp_q;
   logic                 fin_q;

   logic signed [13:0]   coef;
   logic signed [22:0]   prod;

   // Cosine ROM: fold the phase index m=(2n+1)k mod 32 onto the first quadrant.
   function automatic logic signed [13:0] cos_rom(input logic [2:0] k, input logic [2:0] n);
      logic [6:0]         p;
      logic [4:0]         m;
      logic [3:0]         mf;
      logic signed [13:0] mag;
      p = {3'b000, n, 1'b1} * {4'b0000, k};
      m = p[4:0];
      if (m <= 5'd8)
         mf = m[3:0];
      else if (m <= 5'd16)
         mf = 4'(5'd16 - m);
      else if (m <= 5'd24)
         mf = 4'(m - 5'd16);
      else
         mf = 4'(6'd32 - {1'b0, m});
      case (mf)
         4'd0:    mag = 14'sd4096;
         4'd1:    mag = 14'sd4017;
         4'd2:    mag = 14'sd3784;
         4'd3:    mag = 14'sd3406;
         4'd4:    mag = 14'sd2896;
         4'd5:    mag = 14'sd2276;
         4'd6:    mag = 14'sd1567;
         4'd7:    mag = 14'sd799;
         default: mag = 14'sd0;
      endcase
      return ((m > 5'd8) && (m < 5'd24)) ? -mag : mag;
   endfunction

   always_comb begin
      coef  = cos_rom(k_q, n_q);
      prod  = $signed({1'b0, x_q[n_q]}) * coef;
      acc_d = acc_q + AW'(prod);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         x_q     <= '{default: '0};
         ld_q    <= '0;
         k_q     <= '0;
         n_q     <= '0;
         acc_q   <= '0;
         data_q  <= '0;
         exp_q   <= 1'b0;
         fin_q   <= 1'b0;
      end else begin
         exp_q <= 1'b0;
         fin_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  x_q[0]  <= data_in;
                  ld_q    <= 3'd1;
                  state_q <= LOAD;
               end
            end
            LOAD: begin
               x_q[ld_q] <= data_in;
               ld_q      <= ld_q + 3'd1;
               if (ld_q == 3'd7) begin
                  k_q     <= '0;
                  n_q     <= '0;
                  acc_q   <= '0;
                  state_q <= MAC;
               end
            end
            MAC: begin
               n_q <= n_q + 3'd1;
               if (n_q == 3'd7) begin
                  // Last tap of a coefficient: publish the full sum and restart.
                  data_q <= 32'(acc_d);
                  acc_q  <= '0;
                  exp_q  <= 1'b1;
                  k_q    <= k_q + 3'd1;
                  if (k_q == 3'd7) begin
                     fin_q   <= 1'b1;
                     state_q <= IDLE;
                  end
               end else begin
                  acc_q <= acc_d;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign data_out      = data_q;
   assign exportProduct = exp_q;
   assign finish        = fin_q;

endmodule

// File: tb/tb_dct_v2.sv
// Self-checking bench for dct_v2: per-cycle strobe/data checks against a
// floating-point cosine reference, plus directed spot values.
module tb_dct_v2;

   logic               clk;
   logic               reset;
   logic               start;
   logic [7:0]         data_in;
   logic signed [31:0] data_out;
   logic               exportProduct;
   logic               finish;

   dct_v2 dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .data_in       (data_in),
      .data_out      (data_out),
      .exportProduct (exportProduct),
      .finish        (finish)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   logic [7:0]  xv [8];
   logic [31:0] got [8];
   int          got_n;
   logic [31:0] last_exp;

   int unsigned exp_pulses = 0;
   time         fin_t [$];

   always @(negedge clk) begin
      if (exportProduct === 1'b1) exp_pulses++;
      if (finish === 1'b1) fin_t.push_back($time);
   end

   function automatic int ref_coef(input int k, input int n);
      real pi;
      real r;
      pi = 3.141592653589793;
      r  = 4096.0 * $cos(real'((2 * n + 1) * k) * pi / 16.0);
      if (r >= 0.0) return $rtoi(r + 0.5);
      return -$rtoi(-r + 0.5);
   endfunction

   // Runs one frame from IDLE; abort_at >= 0 asserts reset on that edge index.
   task automatic run_frame(input string tag, input bit hold_start, input int abort_at);
      int  expv [8];
      bit  aborted;
      bit  e_exp;
      bit  e_fin;
      for (int k = 0; k < 8; k++) begin
         expv[k] = 0;
         for (int n = 0; n < 8; n++) expv[k] += int'(xv[n]) * ref_coef(k, n);
      end
      got_n   = 0;
      start   = 1'b1;
      data_in = xv[0];
      for (int c = 0; c < 72; c++) begin
         if (c == abort_at) reset = 1'b1;
         @(posedge clk);
         #1;
         aborted = (abort_at >= 0) && (c >= abort_at);
         if (c == abort_at) last_exp = '0;
         e_exp = !aborted && (c >= 15) && (((c - 15) % 8) == 0);
         e_fin = !aborted && (c == 71);
         if (e_exp) last_exp = 32'(expv[(c - 15) / 8]);
         if (exportProduct === 1'b1 && got_n < 8) begin
            got[got_n] = data_out;
            got_n++;
         end
         n_cmp++;
         if (exportProduct !== e_exp) begin
            n_bad++;
            $display("FAIL %s export c=%0d: got %b want %b", tag, c, exportProduct, e_exp);
         end
         n_cmp++;
         if (finish !== e_fin) begin
            n_bad++;
            $display("FAIL %s finish c=%0d: got %b want %b", tag, c, finish, e_fin);
         end
         n_cmp++;
         if (data_out !== last_exp) begin
            n_bad++;
            $display("FAIL %s data_out c=%0d: got %0d want %0d", tag, c, $signed(data_out),
                     $signed(last_exp));
         end
         if (c == abort_at) reset = 1'b0;
         start   = hold_start && !aborted;
         data_in = (c + 1 < 8) ? xv[c + 1] : 8'($urandom);
      end
   endtask

   task automatic test_reset();
      reset   = 1'b1;
      start   = 1'b1;
      data_in = 8'hA5;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         n_cmp++;
         if (data_out !== 32'd0 || exportProduct !== 1'b0 || finish !== 1'b0) begin
            n_bad++;
            $display("FAIL reset: got d=%0d e=%b f=%b want 0/0/0", data_out, exportProduct, finish);
         end
      end
      reset    = 1'b0;
      start    = 1'b0;
      last_exp = '0;
   endtask

   task automatic test_idle();
      start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         data_in = 8'($urandom);
         @(posedge clk);
         #1;
         n_cmp++;
         if (data_out !== last_exp || exportProduct !== 1'b0 || finish !== 1'b0) begin
            n_bad++;
            $display("FAIL idle: got d=%0d e=%b f=%b want d=%0d e=0 f=0", $signed(data_out),
                     exportProduct, finish, $signed(last_exp));
         end
      end
   endtask

   task automatic test_impulse();
      int want [8] = '{4096, 4017, 3784, 3406, 2896, 2276, 1567, 799};
      foreach (xv[i]) xv[i] = (i == 0) ? 8'd1 : 8'd0;
      run_frame("impulse", 1'b0, -1);
      for (int k = 0; k < 8; k++) begin
         n_cmp++;
         if (got[k] !== 32'(want[k])) begin
            n_bad++;
            $display("FAIL impulse X%0d: got %0d want %0d", k, $signed(got[k]), want[k]);
         end
      end
   endtask

   task automatic test_dc();
      foreach (xv[i]) xv[i] = 8'd100;
      run_frame("dc", 1'b0, -1);
      for (int k = 0; k < 8; k++) begin
         n_cmp++;
         if (got[k] !== ((k == 0) ? 32'd3276800 : 32'd0)) begin
            n_bad++;
            $display("FAIL dc X%0d: got %0d want %0d", k, $signed(got[k]), (k == 0) ? 3276800 : 0);
         end
      end
   endtask

   task automatic test_ramp_sign();
      logic [31:0] hi;
      foreach (xv[i]) xv[i] = 8'(i);
      run_frame("ramp", 1'b0, -1);
      n_cmp++;
      if (got[0] !== 32'd114688) begin
         n_bad++;
         $display("FAIL ramp X0: got %0d want 114688", $signed(got[0]));
      end
      n_cmp++;
      if (got[1] !== 32'hFFFF_31D8) begin
         n_bad++;
         $display("FAIL ramp X1: got %0d want -52776", $signed(got[1]));
      end
      hi = got[1];
      n_cmp++;
      if (hi[31:24] !== 8'hFF) begin
         n_bad++;
         $display("FAIL sign_ext upper byte: got %h want ff", hi[31:24]);
      end
   endtask

   task automatic test_max_alt();
      foreach (xv[i]) xv[i] = (i % 2 == 0) ? 8'd255 : 8'd0;
      run_frame("maxalt", 1'b0, -1);
      n_cmp++;
      if (got[0] !== 32'd4177920) begin
         n_bad++;
         $display("FAIL maxalt X0: got %0d want 4177920", $signed(got[0]));
      end
   endtask

   task automatic test_random();
      for (int f = 0; f < 4; f++) begin
         foreach (xv[i]) xv[i] = 8'($urandom);
         run_frame("random", 1'b0, -1);
      end
   endtask

   task automatic test_midframe_reset();
      foreach (xv[i]) xv[i] = 8'($urandom);
      run_frame("abort", 1'b0, 40);
      foreach (xv[i]) xv[i] = 8'($urandom);
      run_frame("post_abort", 1'b0, -1);
   endtask

   task automatic test_back_to_back();
      exp_pulses = 0;
      fin_t.delete();
      foreach (xv[i]) xv[i] = 8'($urandom);
      run_frame("b2b_0", 1'b1, -1);
      foreach (xv[i]) xv[i] = 8'($urandom);
      run_frame("b2b_1", 1'b0, -1);
      repeat (4) @(posedge clk);
      #1;
      n_cmp++;
      if (exp_pulses != 16) begin
         n_bad++;
         $display("FAIL b2b export count: got %0d want 16", exp_pulses);
      end
      n_cmp++;
      if (fin_t.size() != 2) begin
         n_bad++;
         $display("FAIL b2b finish count: got %0d want 2", fin_t.size());
      end else begin
         n_cmp++;
         if (fin_t[1] - fin_t[0] != 720) begin
            n_bad++;
            $display("FAIL b2b finish spacing: got %0t want 720", fin_t[1] - fin_t[0]);
         end
      end
   endtask

   initial begin
      reset    = 1'b0;
      start    = 1'b0;
      data_in  = '0;
      last_exp = '0;
      got_n    = 0;
      test_reset();
      test_idle();
      test_impulse();
      test_dc();
      test_ramp_sign();
      test_max_alt();
      test_random();
      test_midframe_reset();
      test_idle();
      test_back_to_back();
      test_idle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dct_v2.md
DCT_V2 -- requirements
Module: dct_v2

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset; ports SHALL be listed clock and reset first.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 start  input  1  frame request, sampled only in IDLE.
REQ-005 data_in  input  8  unsigned input sample x[n].
REQ-006 data_out  output  32  signed DCT coefficient X[k], registered.
REQ-007 exportProduct  output  1  one-cycle strobe: data_out holds a new valid X[k].
REQ-008 finish  output  1  one-cycle strobe: frame complete.

Function
REQ-009 The block SHALL compute an unnormalized 8-point 1-D DCT-II per frame: X[k] = sum over n=0..7 of x[n]*C[k][n], for k=0..7.
REQ-010 C[k][n] SHALL be round(4096*cos((2n+1)k*pi/16)), stored as a signed 14-bit ROM; with m = ((2n+1)k) mod 32, the magnitude is T[m'], where m' is m folded into 0..8.
REQ-011 Table T[0..8] SHALL be 4096, 4017, 3784, 3406, 2896, 2276, 1567, 799, 0.
REQ-012 The sign of C[k][n] SHALL be negative for 8<m<24 and positive otherwise.
REQ-013 Arithmetic SHALL use x zero-extended, signed products, and a signed accumulator of at least 26 bits, sign-extended to 32 bits on data_out; there SHALL be no rounding, scaling or saturation.
REQ-014 The FSM SHALL have states IDLE, LOAD, MAC.
REQ-015 In IDLE with start=1 at edge E0, the block SHALL capture data_in as x[0] and enter LOAD.
REQ-016 LOAD SHALL capture x[1]..x[7] at edges E1..E7 unconditionally, with start ignored, then enter MAC.
REQ-017 MAC SHALL add one product per edge, over 8 edges per coefficient, at edges E8..E71, in order k=0..7 and n=0..7.
REQ-018 At the 8th edge of coefficient k (edge E15+8k), data_out SHALL load the complete X[k], the accumulator SHALL clear, and exportProduct SHALL be 1 for the following cycle only.
REQ-019 At edge E71, the block SHALL also assert finish for one cycle, coincident with the X[7] exportProduct, and return to IDLE.
REQ-020 With start still 1 in IDLE, a new frame SHALL begin at E72, giving a frame period of 72 cycles.
REQ-021 data_out SHALL hold its last value between strobes; exportProduct and finish SHALL be 0 at all other times.
REQ-022 In IDLE with start=0, the block SHALL remain idle, with outputs held and strobes 0.

Reset
REQ-023 reset=1 at a rising edge SHALL force IDLE, data_out=0, exportProduct=0 and finish=0, and clear the sample registers, accumulator and counters.
REQ-024 Reset SHALL take priority over start and over any state.
REQ-025 Reset mid-frame SHALL abort the frame with no further strobes; the partial frame SHALL never be resumed.

Verification
REQ-026 Impulse: x = 1,0,0,0,0,0,0,0 -> 8 exports with data_out = 4096, 4017, 3784, 3406, 2896, 2276, 1567, 799; finish occurs with the 8th export.
REQ-027 DC: all x = 100 -> X[0] = 3276800, X[1..7] = 0; exports occur in the cycles after E15, E23, ..., E71.
REQ-028 Ramp: x = 0..7 -> X[0] = 114688, X[1] = -52776; the remaining X[k] are checked against a REQ-010 golden model.
REQ-029 Max/alternating: x = 255,0,255,0,255,0,255,0 -> X[0] = 4177920; a negative X[k] (such as the ramp's X[1]) is checked for correct 32-bit sign extension.
REQ-030 Reset is asserted at E40 -> data_out = 0 and no strobes follow; with start=1 afterwards, a fresh frame yields correct results.
REQ-031 With start held high, two back-to-back frames -> finish pulses exactly 72 cycles apart, with 16 exportProduct pulses in total.
